// File: rtl/uart_program_loader.sv
// Boot loader: takes header + data words from the UART receiver, writes them to instruction
// memory, then releases the CPU from reset. Optional checksum word via LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       rx_word_data,
  input  logic              rx_word_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam logic [16:0] MaxN = 17'(1) << ADDR_W;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StWaitHdr,
    StLoad,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StRun,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [CntW-1:0]   words_q, words_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [16:0]       hdr_n;
  logic              hdr_ok;
  logic              timed_out;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  assign hdr_n     = {1'b0, rx_word_data[15:0]};
  assign hdr_ok    = (rx_word_data[31:16] == 16'hA5A5) && (hdr_n != 17'd0) && (hdr_n <= MaxN);
  assign timed_out = (timer_q == TmrLast);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    words_d   = words_q;
    timer_d   = timer_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    // reload wins over a coincident strobe; that word is dropped
    if (reload) begin
      state_d = StWaitHdr;
      words_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        StWaitHdr: begin
          if (rx_word_ready) begin
            if (hdr_ok) begin
              n_d     = hdr_n[CntW-1:0];
              timer_d = '0;
`ifdef LOADER_CHECKSUM_EN
              sum_d   = '0;
`endif
              state_d = StLoad;
            end else begin
              state_d = StError;
            end
          end
        end
        StLoad: begin
          if (rx_word_ready) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = rx_word_data;
            words_d = words_q + CntW'(1);
            timer_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + rx_word_data;
            if (words_d == n_q) state_d = StCheck;
`else
            if (words_d == n_q) state_d = StRun;
`endif
          end else if (timed_out) begin
            state_d = StError;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (rx_word_ready) begin
            timer_d = '0;
            state_d = (rx_word_data == sum_q) ? StRun : StError;
          end else if (timed_out) begin
            state_d = StError;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
    // one-cycle lag guarantees the last write lands before the CPU runs
    cpu_rst_n_d = (state_q == StRun) && !reload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitHdr;
      n_q         <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      words_q     <= words_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign words_loaded = words_q;
  assign load_done    = (state_q == StRun);
  assign load_error   = (state_q == StError);
  assign load_busy    = !load_done && !load_error;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: per-cycle behavioural model check plus directed literal checks.
module tb_uart_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;
  localparam int MW = 0, ML = 1, MC = 2, MR = 3, ME = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   rx_word_data = '0;
  logic          rx_word_ready = 1'b0;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n, load_busy, load_done, load_error;
  logic [AW:0]   words_loaded;

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  uart_program_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_word_data(rx_word_data), .rx_word_ready(rx_word_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: loader phase, counts and the write expected for the coming cycle
  int          m_mode = MW, m_n = 0, m_cnt = 0, m_idle = 0;
  logic [31:0] m_sum = '0;
  logic        e_we = 1'b0, e_cpu = 1'b0;
  int          e_addr = 0;
  logic [31:0] e_wdata = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = MW; m_cnt = 0; m_idle = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_cpu = 0;
    end else begin
      int hn;
      e_cpu = (m_mode == MR) && !reload;
      e_we  = 0;
      hn    = int'(rx_word_data[15:0]);
      if (reload) begin
        m_mode = MW; m_cnt = 0; m_idle = 0;
      end else if (m_mode == MW && rx_word_ready) begin
        if (rx_word_data[31:16] == 16'hA5A5 && hn >= 1 && hn <= (1 << AW)) begin
          m_n = hn; m_sum = 0; m_idle = 0; m_mode = ML;
        end else m_mode = ME;
      end else if (m_mode == ML || m_mode == MC) begin
        if (rx_word_ready) begin
          m_idle = 0;
          if (m_mode == ML) begin
            e_we = 1; e_addr = m_cnt; e_wdata = rx_word_data;
            m_cnt++; m_sum += rx_word_data;
`ifdef LOADER_CHECKSUM_EN
            if (m_cnt == m_n) m_mode = MC;
`else
            if (m_cnt == m_n) m_mode = MR;
`endif
          end else begin
            m_mode = (rx_word_data == m_sum) ? MR : ME;
          end
        end else begin
          m_idle++;
          if (m_idle >= TO) m_mode = ME;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      check("m_we", 32'(imem_we), 32'(e_we));
      if (e_we) begin
        check("m_addr", 32'(imem_addr), 32'(e_addr));
        check("m_wdata", imem_wdata, e_wdata);
      end
      check("m_cpu_rst_n", 32'(cpu_rst_n), 32'(e_cpu));
      check("m_busy", 32'(load_busy), 32'(m_mode == MW || m_mode == ML || m_mode == MC));
      check("m_done", 32'(load_done), 32'(m_mode == MR));
      check("m_error", 32'(load_error), 32'(m_mode == ME));
      check("m_words", 32'(words_loaded), 32'(m_cnt));
    end
  end

  task automatic word(input logic [31:0] w);
    @(negedge clk);
    rx_word_data = w; rx_word_ready = 1'b1; reload = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_word_ready = 1'b0; reload = 1'b0;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    rx_word_ready = 1'b0; reload = 1'b1;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_busy"}, 32'(load_busy), 32'd1);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int k;
    #2 check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic three-word load
    word(32'hA5A5_0003); word(32'h11); word(32'h22); word(32'h33);
`ifdef LOADER_CHECKSUM_EN
    word(32'h66);
    idle(1);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_cpu_lag", 32'(cpu_rst_n), 32'd0);
`else
    idle(1);
    check("t1_last_we", 32'(imem_we), 32'd1);
    check("t1_last_addr", 32'(imem_addr), 32'd2);
    check("t1_last_data", imem_wdata, 32'h33);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_cpu_lag", 32'(cpu_rst_n), 32'd0);
`endif
    idle(1);
    check("t1_cpu_up", 32'(cpu_rst_n), 32'd1);
    check("t1_words", 32'(words_loaded), 32'd3);

    // Words in RUN are ignored
    word(32'h99); idle(1);
    check("run_ignore_we", 32'(imem_we), 32'd0);
    check("run_ignore_words", 32'(words_loaded), 32'd3);

    // reload together with a strobe: reload wins
    @(negedge clk);
    rx_word_data = 32'hA5A5_0001; rx_word_ready = 1'b1; reload = 1'b1;
    idle(1);
    check("rl_we", 32'(imem_we), 32'd0);
    check("rl_busy", 32'(load_busy), 32'd1);
    check("rl_cpu", 32'(cpu_rst_n), 32'd0);
    check("rl_words", 32'(words_loaded), 32'd0);

    // Header errors
    word(32'h1234_0002); idle(1);
    check("bad_magic_err", 32'(load_error), 32'd1);
    check("bad_magic_we", 32'(imem_we), 32'd0);
    do_reload();
    word(32'hA5A5_0000); idle(1);
    check("n_zero_err", 32'(load_error), 32'd1);
    do_reload();
    word(32'hA5A5_0011); idle(1);
    check("n_big_err", 32'(load_error), 32'd1);
    do_reload();

    // N = 2^ADDR_W, back-to-back strobes
    word(32'hA5A5_0010);
    for (int i = 0; i < 16; i++) word(32'h100 + 32'(i));
`ifdef LOADER_CHECKSUM_EN
    word(32'h0000_1078);
`endif
    idle(2);
    check("full_done", 32'(load_done), 32'd1);
    check("full_words", 32'(words_loaded), 32'd16);
    do_reload();

    // Inter-word timeout
    word(32'hA5A5_0002); word(32'hDEAD_BEEF); idle(1);
    k = 0;
    while (!load_error && k < 40) begin
      idle(1);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'd16);
    check("timeout_words", 32'(words_loaded), 32'd1);
    do_reload();

`ifdef LOADER_CHECKSUM_EN
    word(32'hA5A5_0002); word(32'hFFFF_FFFF); word(32'h2); word(32'h1); idle(1);
    check("ck_ok_done", 32'(load_done), 32'd1);
    idle(1);
    check("ck_ok_cpu", 32'(cpu_rst_n), 32'd1);
    do_reload();
    word(32'hA5A5_0002); word(32'hFFFF_FFFF); word(32'h2); word(32'h2); idle(1);
    check("ck_bad_err", 32'(load_error), 32'd1);
    check("ck_bad_we", 32'(imem_we), 32'd0);
    idle(1);
    check("ck_bad_cpu", 32'(cpu_rst_n), 32'd0);
    do_reload();
`endif

    // Asynchronous reset mid-load, then a fresh load from address 0
    word(32'hA5A5_0003); word(32'hAA); idle(1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk); rst_n = 1'b1;
    word(32'hA5A5_0001); word(32'h77); idle(1);
    check("restart_we", 32'(imem_we), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    check("restart_data", imem_wdata, 32'h77);
`ifdef LOADER_CHECKSUM_EN
    word(32'h77); idle(1);
`endif
    check("restart_done", 32'(load_done), 32'd1);

    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
